// File: rtl/wb_dma_master.sv
// Wishbone memory-to-memory copy engine: reads one 32-bit word, writes it back out,
// and repeats for len words, with per-phase ACK timeout and external abort.
module wb_dma_master #(
  parameter int TIMEOUT = 255,
  parameter int LEN_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [31:0]      i_src_addr,
  input  logic [31:0]      i_dst_addr,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [LEN_W-1:0] o_count,
  output logic             o_stb,
  output logic             o_we,
  output logic [31:0]      o_addr,
  output logic [31:0]      o_dat,
  input  logic [31:0]      i_dat,
  input  logic             i_ack
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR       = 3'd3,
    ST_NEXT     = 3'd4,
    ST_FIN      = 3'd5
  } state_t;

  state_t           r_state;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [31:0]      r_addr;
  logic [31:0]      r_buf;
  logic [LEN_W-1:0] r_rem;
  logic [LEN_W-1:0] r_count;
  logic [TW-1:0]    r_tmo;
  logic             r_stb;
  logic             r_we;
  logic             r_busy;
  logic             r_done;
  logic             r_error;

  // Sequencer: state, bus outputs and status are all registered together so
  // STB/WE/ADDR always line up with the state that owns the bus cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_src   <= 32'd0;
      r_dst   <= 32'd0;
      r_addr  <= 32'd0;
      r_buf   <= 32'd0;
      r_rem   <= '0;
      r_count <= '0;
      r_tmo   <= '0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_src   <= {i_src_addr[31:2], 2'b00};
            r_dst   <= {i_dst_addr[31:2], 2'b00};
            r_rem   <= i_len;
            r_count <= '0;
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            r_tmo   <= '0;
            if (i_len == '0) begin
              r_state <= ST_FIN;
            end else begin
              r_state <= ST_RD;
              r_stb   <= 1'b1;
              r_we    <= 1'b0;
              r_addr  <= {i_src_addr[31:2], 2'b00};
            end
          end
        end
        ST_RD: begin
          if (i_abort || (!i_ack && r_tmo == TMO_LAST)) begin
            r_state <= ST_FIN;
            r_stb   <= 1'b0;
            r_error <= 1'b1;
          end else if (i_ack) begin
            r_buf   <= i_dat;
            r_stb   <= 1'b0;
            r_state <= ST_WR_SETUP;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        ST_WR_SETUP: begin
          if (i_abort) begin
            r_state <= ST_FIN;
            r_error <= 1'b1;
          end else begin
            r_state <= ST_WR;
            r_stb   <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= r_dst;
            r_tmo   <= '0;
          end
        end
        ST_WR: begin
          // abort outranks a same-edge ACK, so the word is not counted
          if (i_abort || (!i_ack && r_tmo == TMO_LAST)) begin
            r_state <= ST_FIN;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_error <= 1'b1;
          end else if (i_ack) begin
            r_src   <= r_src + 32'd4;
            r_dst   <= r_dst + 32'd4;
            r_count <= r_count + LEN_W'(1);
            r_rem   <= r_rem - LEN_W'(1);
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= ST_NEXT;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        ST_NEXT: begin
          if (i_abort) begin
            r_state <= ST_FIN;
            r_error <= 1'b1;
          end else if (r_rem != '0) begin
            r_state <= ST_RD;
            r_stb   <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= r_src;
            r_tmo   <= '0;
          end else begin
            r_state <= ST_FIN;
          end
        end
        ST_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_stb   <= 1'b0;
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_error = r_error;
  assign o_count = r_count;
  assign o_stb   = r_stb;
  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_dat   = r_buf;

endmodule

// File: tb/tb_wb_dma_master.sv
// Directed bench for wb_dma_master: RAM-model slave with tied, delayed or absent ACK;
// expected cycle counts and data are hand-computed per scenario.
module tb_wb_dma_master;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len;
  logic        busy, done, error;
  logic [15:0] count;
  logic        stb, we;
  logic [31:0] addr, dat_o, dat_i;
  logic        ack;

  logic [31:0] mem [0:255];
  int          ack_mode;   // 0 tied high, 1 delayed, 2 never
  int          ack_delay;
  int          stb_wait;
  int          n_vec = 0;
  int          n_miss = 0;
  logic        stb_hist [0:255];
  int          stb_total, busy_cnt;
  logic [31:0] rd_log [$];
  int          dc;

  wb_dma_master #(.TIMEOUT(8), .LEN_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_src_addr(src_addr), .i_dst_addr(dst_addr), .i_len(len),
    .o_busy(busy), .o_done(done), .o_error(error), .o_count(count),
    .o_stb(stb), .o_we(we), .o_addr(addr), .o_dat(dat_o),
    .i_dat(dat_i), .i_ack(ack)
  );

  always #5 clk = ~clk;

  assign dat_i = mem[addr[9:2]];
  assign ack   = (ack_mode == 0) ? 1'b1 :
                 (ack_mode == 1) ? (stb && (stb_wait >= ack_delay)) : 1'b0;

  // cycles STB has been waiting for ACK in the current phase
  always @(posedge clk) stb_wait <= (stb && !ack) ? stb_wait + 1 : 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Start a copy at the current negedge and step one cycle per negedge until done
  // or the budget runs out; optionally abort, re-pulse start or reset on a given cycle.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input int abort_at, input int restart_at, input int rst_at,
                          input int budget, output int done_cyc);
    int cyc;
    done_cyc = 0;
    stb_total = 0;
    busy_cnt = 0;
    rd_log.delete();
    for (int i = 0; i < 256; i++) stb_hist[i] = 1'b0;
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc <= budget) begin
      stb_hist[cyc[7:0]] = stb;
      if (stb) stb_total++;
      if (busy) busy_cnt++;
      if (stb && !we && ack) rd_log.push_back(addr);
      if (stb && we && ack) mem[addr[9:2]] = dat_o;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      abort = (cyc == abort_at);
      rst   = (cyc == rst_at);
      if (cyc == restart_at) begin
        start = 1'b1; src_addr = 32'h0000_0080; dst_addr = 32'h0000_0700; len = 16'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    abort = 1'b0; start = 1'b0; rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i * 4;
    ack_mode = 0; ack_delay = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    src_addr = 32'd0; dst_addr = 32'd0; len = 16'd0;
    repeat (2) @(negedge clk);
    check_value("rst_stb",   {31'd0, stb},   32'd0);
    check_value("rst_we",    {31'd0, we},    32'd0);
    check_value("rst_busy",  {31'd0, busy},  32'd0);
    check_value("rst_done",  {31'd0, done},  32'd0);
    check_value("rst_error", {31'd0, error}, 32'd0);
    check_value("rst_count", {16'd0, count}, 32'd0);
    check_value("rst_addr",  addr,           32'd0);
    check_value("rst_dat",   dat_o,          32'd0);
    rst = 1'b0;
    @(negedge clk);

    // three words, ACK tied high: 4 cycles per word, FIN on 13, done on 14
    run_copy(32'h100, 32'h200, 16'd3, 0, 0, 0, 60, dc);
    check_value("t3_done_cyc", dc,              32'd14);
    check_value("t3_count",    {16'd0, count},  32'd3);
    check_value("t3_error",    {31'd0, error},  32'd0);
    check_value("t3_stb_cyc",  stb_total,       32'd6);
    check_value("t3_busy_cyc", busy_cnt,        32'd13);
    check_value("t3_w0",       mem[8'h80],      32'h100);
    check_value("t3_w1",       mem[8'h81],      32'h104);
    check_value("t3_w2",       mem[8'h82],      32'h108);
    @(negedge clk);
    check_value("t3_done_1cy", {31'd0, done},   32'd0);

    // zero length: FIN straight away, no bus traffic
    run_copy(32'h100, 32'h200, 16'd0, 0, 0, 0, 20, dc);
    check_value("z_done_cyc", dc,              32'd2);
    check_value("z_count",    {16'd0, count},  32'd0);
    check_value("z_stb_cyc",  stb_total,       32'd0);
    check_value("z_busy_cyc", busy_cnt,        32'd1);
    @(negedge clk);

    // ACK in the 6th STB cycle of each phase, two words
    ack_mode = 1; ack_delay = 5;
    run_copy(32'h40, 32'h300, 16'd2, 0, 0, 0, 80, dc);
    check_value("d_done_cyc", dc,              32'd30);
    check_value("d_stb_cyc",  stb_total,       32'd24);
    check_value("d_count",    {16'd0, count},  32'd2);
    check_value("d_w0",       mem[8'hC0],      32'h40);
    check_value("d_w1",       mem[8'hC1],      32'h44);
    @(negedge clk);

    // no ACK ever: 8 STB cycles then timeout
    ack_mode = 2;
    run_copy(32'h100, 32'h200, 16'd3, 0, 0, 0, 40, dc);
    check_value("to_done_cyc", dc,              32'd10);
    check_value("to_stb_cyc",  stb_total,       32'd8);
    check_value("to_error",    {31'd0, error},  32'd1);
    check_value("to_count",    {16'd0, count},  32'd0);
    @(negedge clk);
    check_value("to_sticky",   {31'd0, error},  32'd1);
    ack_mode = 0;
    run_copy(32'h100, 32'h200, 16'd0, 0, 0, 0, 20, dc);
    check_value("to_clr_err",  {31'd0, error},  32'd0);
    @(negedge clk);

    // abort in word 2's WR cycle (cycle 7) with ACK high
    run_copy(32'h100, 32'h200, 16'd4, 7, 0, 0, 40, dc);
    check_value("ab_wr_stb",   {31'd0, stb_hist[7]}, 32'd1);
    check_value("ab_stb_next", {31'd0, stb_hist[8]}, 32'd0);
    check_value("ab_done_cyc", dc,              32'd9);
    check_value("ab_count",    {16'd0, count},  32'd1);
    check_value("ab_error",    {31'd0, error},  32'd1);
    @(negedge clk);

    // address wrap, plus a second start while busy that must be ignored
    mem[0] = 32'hCAFE_0000;
    run_copy(32'hFFFF_FFFC, 32'h500, 16'd2, 0, 3, 0, 40, dc);
    check_value("wr_done_cyc", dc,              32'd10);
    check_value("wr_count",    {16'd0, count},  32'd2);
    check_value("wr_nreads",   rd_log.size(),   32'd2);
    if (rd_log.size() == 2) begin
      check_value("wr_rd0", rd_log[0], 32'hFFFF_FFFC);
      check_value("wr_rd1", rd_log[1], 32'h0000_0000);
    end
    check_value("wr_w0", mem[8'h40], 32'h3FC);
    check_value("wr_w1", mem[8'h41], 32'hCAFE_0000);
    @(negedge clk);

    // reset in cycle 3 of a copy: STB low next cycle, no done at all
    run_copy(32'h100, 32'h600, 16'd4, 0, 0, 3, 20, dc);
    check_value("rs_stb_c3",   {31'd0, stb_hist[3]}, 32'd1);
    check_value("rs_stb_next", {31'd0, stb_hist[4]}, 32'd0);
    check_value("rs_no_done",  dc,              32'd0);
    check_value("rs_busy",     {31'd0, busy},   32'd0);
    check_value("rs_count",    {16'd0, count},  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/wb_dma_master.md
WB_DMA_MASTER -- requirements
Module: wb_dma_master

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles STB may stay high without ACK before the transfer aborts.
REQ-002 Parameter LEN_W, default 16: width of the length and count fields.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 start  in  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 abort  in  1  terminate an active copy.
REQ-007 src_addr  in  32  byte address of the first source word.
REQ-008 dst_addr  in  32  byte address of the first destination word.
REQ-009 len  in  LEN_W  number of 32-bit words to copy.
REQ-010 busy  out  1  high from the cycle after start acceptance until FIN exits.
REQ-011 done  out  1  one-cycle pulse at end of every accepted copy.
REQ-012 error  out  1  sticky: timeout or abort occurred; cleared on the next accepted start.
REQ-013 count  out  LEN_W  words fully written in the current/last copy.
REQ-014 STB  out  1  bus strobe (master side of WB_intercon).
REQ-015 WE  out  1  bus write enable; valid only while STB=1.
REQ-016 ADDR  out  32  bus byte address; bits [1:0] always 0.
REQ-017 DAT_O  out  32  write data to bus.
REQ-018 DAT_I  in  32  read data from bus.
REQ-019 ACK  in  1  slave acknowledge; may be constantly high.

Function
REQ-020 States: IDLE, RD, WR_SETUP, WR, NEXT, FIN; STB=1 only in RD and WR.
REQ-021 IDLE, start=1: latch src/dst with bits [1:0] forced to 0, latch len, clear count and error; go RD, or FIN if len=0 (no bus traffic).
REQ-022 start while not IDLE shall be ignored, with no effect on latched values.
REQ-023 RD: STB=1, WE=0, ADDR=src; at an edge with ACK=1, capture DAT_I into the data buffer and go WR_SETUP.
REQ-024 WR_SETUP: STB=0 for exactly one cycle, then WR.
REQ-025 WR: STB=1, WE=1, ADDR=dst, DAT_O=buffer; at an edge with ACK=1: src+=4, dst+=4, count+=1, remaining-=1; go NEXT.
REQ-026 NEXT: STB=0 for one cycle; go RD if remaining!=0, else FIN.
REQ-027 Address increments wrap modulo 2^32 without error.
REQ-028 ACK=1 in the first STB cycle completes that phase in one cycle; with constant ACK, each word takes 4 cycles (RD, WR_SETUP, WR, NEXT).
REQ-029 ACK while STB=0 shall be ignored.
REQ-030 Timeout counter clears on entry to RD/WR and increments each STB cycle without ACK; when it reaches TIMEOUT, drop STB at that edge, set error, go FIN; count is unchanged.
REQ-031 abort=1 in RD, WR_SETUP, WR or NEXT: go FIN at that edge, set error, STB=0 next cycle.
REQ-032 abort with ACK in the same edge: abort wins; a WR phase ACKed in that edge shall not increment count.
REQ-033 abort in IDLE or FIN shall be ignored.
REQ-034 FIN: done=1 for one cycle, STB=0; next state IDLE; busy drops with done.
REQ-035 DAT_O holds the buffer value outside WR; WE=0 whenever STB=0.

Reset
REQ-036 While rst=1 at an edge: state=IDLE; STB, WE, busy, done, error = 0; count=0; ADDR=0; DAT_O=0.
REQ-037 rst asserted mid-copy shall drop STB at that edge with no done pulse; the copy is discarded.

Verification
REQ-038 ACK tied 1, RAM model, src=0x100, dst=0x200, len=3 -> 12 bus cycles; words 0x100/0x104/0x108 appear at 0x200/0x204/0x208; done on cycle 14 after start; count=3; error=0.
REQ-039 len=0 -> no STB; done one cycle after busy rises; count=0.
REQ-040 ACK delayed 5 cycles per phase, len=2 -> STB held through each delay; data correct; count=2.
REQ-041 ACK never returned, TIMEOUT=8 -> STB high 8 cycles, then error=1, done pulse, count=0; next start clears error.
REQ-042 abort in the WR cycle where ACK=1 on word 2 of 4 -> count=1, error=1, done pulse, STB=0 next cycle.
REQ-043 src_addr=0xFFFFFFFC, len=2, and start pulsed again while busy -> second read at 0x00000000; second start ignored; rst mid-copy -> STB=0 next cycle, no done.
